// File: rtl/mem_bus_pkg.sv
// Shared definitions for the external asynchronous SRAM bus reader/writer blocks.
package mem_bus_pkg;

    localparam int unsigned MEM_ADDR_W = 12;
    localparam int unsigned MEM_DATA_W = 16;
    localparam int unsigned REG_AW     = 3;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MAX_WORDS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        WRITE,
        DONE
    } state_t;

    // Requests above the register-file depth are trimmed to a full file.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : c;
    endfunction

endpackage

// File: rtl/mem_block_reader.sv
// Block reader: fetches 1..8 consecutive SRAM words and writes them into
// register-file entries 0..count-1. Never drives the SRAM data bus.
module mem_block_reader #(
    parameter int unsigned ADDR_W      = mem_bus_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W      = mem_bus_pkg::MEM_DATA_W,
    parameter int unsigned REG_AW      = mem_bus_pkg::REG_AW,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              mem_data_oe,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata
);

    import mem_bus_pkg::state_t, mem_bus_pkg::IDLE, mem_bus_pkg::ADDR,
           mem_bus_pkg::STROBE, mem_bus_pkg::WRITE, mem_bus_pkg::DONE,
           mem_bus_pkg::CNT_W, mem_bus_pkg::clamp_count;

    localparam int unsigned WAIT_W = 4;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REG_AW-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic                busy_d, done_d, oe_n_d, reg_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [REG_AW-1:0]   reg_waddr_d;
    logic [DATA_W-1:0]   reg_wdata_d;

    logic [CNT_W-1:0]    start_cnt;
    logic [REG_AW-1:0]   idx_inc;
    logic                last_word;

    assign start_cnt = clamp_count(count);
    assign idx_inc   = idx_q + REG_AW'(1);
    assign last_word = (CNT_W'(idx_q) + CNT_W'(1)) >= cnt_q;

    // The reader only ever listens on the data bus.
    assign mem_we_n    = 1'b1;
    assign mem_data_oe = 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = (start_cnt == '0) ? DONE : ADDR;
            ADDR:    state_d = STROBE;
            STROBE:  if (wait_q == '0) state_d = WRITE;
            WRITE:   state_d = last_word ? DONE : ADDR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; everything is registered below
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        oe_n_d      = (state_d != STROBE);
        reg_we_d    = (state_d == WRITE);
        mem_addr_d  = mem_addr;
        reg_waddr_d = reg_waddr;
        reg_wdata_d = reg_wdata;
        base_d      = base_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    cnt_d  = start_cnt;
                    idx_d  = '0;
                    if (start_cnt != '0) mem_addr_d = base_addr;
                end
            end
            ADDR: wait_d = WAIT_W'(WAIT_STATES);
            STROBE: begin
                if (wait_q == '0) begin
                    reg_wdata_d = mem_data_in;
                    reg_waddr_d = idx_q;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            WRITE: begin
                if (!last_word) begin
                    idx_d      = idx_inc;
                    mem_addr_d = base_q + ADDR_W'(idx_inc);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_oe_n  <= 1'b1;
            reg_we    <= 1'b0;
            mem_addr  <= '0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            mem_oe_n  <= oe_n_d;
            reg_we    <= reg_we_d;
            mem_addr  <= mem_addr_d;
            reg_waddr <= reg_waddr_d;
            reg_wdata <= reg_wdata_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
        end
    end

endmodule
